// File: rtl/ttl_reg_file.sv
// ttl_reg_file: multi-word register file with one write port and two tri-state read ports.
// Writes need both active-low write enables low. Each read port needs both of its
// active-low output enables low, otherwise it floats. Reads are combinational.
// Addresses at or above DEPTH are write-ignored and read as zero.
// The optional bypass forwards the write data to a matching read port in the write cycle.

module ttl_reg_file #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned BYPASS = 0,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  d,
    input  logic              we1_n,
    input  logic              we2_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic              oea1_n,
    input  logic              oea2_n,
    output logic [WIDTH-1:0]  qa,
    input  logic [ADDR_W-1:0] rb,
    input  logic              oeb1_n,
    input  logic              oeb2_n,
    output logic [WIDTH-1:0]  qb
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic wr_en;
    logic wa_ok;
    logic ra_ok;
    logic rb_ok;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;

    assign wr_en = ~we1_n & ~we2_n;
    assign wa_ok = {1'b0, wa} < DEPTH_CMP;
    assign ra_ok = {1'b0, ra} < DEPTH_CMP;
    assign rb_ok = {1'b0, rb} < DEPTH_CMP;

    // Next-state contents: only an enabled, in-range write changes one word.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && wa_ok) begin
            mem_d[wa] = d;
        end
    end

    // Storage update; reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Port A read data, with optional same-cycle forwarding of an accepted write.
    always_comb begin
        rdata_a = '0;
        if (ra_ok) begin
            rdata_a = mem_q[ra];
        end
        if ((BYPASS != 0) && wr_en && wa_ok && !rst && (ra == wa)) begin
            rdata_a = d;
        end
    end

    // Port B read data, same rule as port A.
    always_comb begin
        rdata_b = '0;
        if (rb_ok) begin
            rdata_b = mem_q[rb];
        end
        if ((BYPASS != 0) && wr_en && wa_ok && !rst && (rb == wa)) begin
            rdata_b = d;
        end
    end

    // Output enables gate the buses purely combinationally.
    assign qa = (!oea1_n && !oea2_n) ? rdata_a : 'z;
    assign qb = (!oeb1_n && !oeb2_n) ? rdata_b : 'z;

endmodule
